sdram_burst_arb: RTL and testbench
==================================

SDRAM_BURST_ARB -- requirements
Module: sdram_burst_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): BL 4 burst length in words; CL 2 CAS latency in cycles; T_RCD 2 ACTIVE-to-READ/WRITE cycles; T_RP 2 PRECHARGE-to-next-command cycles; T_WR 2 write-recovery cycles; T_RFC 7 refresh-to-next-command cycles; REF_PERIOD 780 refresh interval in cycles.
REQ-002 The block SHALL have these ports (name, direction, width, meaning): clk in 1 clock; rst in 1 asynchronous active-high reset; init_done in 1 SDRAM power-up sequence complete.
REQ-003 Request ports: sdram_rd_req in 1; sdram_rd_ack out 1; sys_rdaddr in 24; sdram_wr_req in 1; sdram_wr_ack out 1; sys_wraddr in 24.
REQ-004 Data-strobe ports: sdram_wr_data_valid out 1 (write word is on the bus); sdram_data_i_valid out 1 (read word is on sdram_data_i); end_tread out 1; end_twrite out 1; sdram_r_wn out 1 (1 = read/idle, 0 = drive DQ).
REQ-005 Status and device ports: work_state out 5; sdram_cmd out 4 {cs_n,ras_n,cas_n,we_n}; sdram_ba out 2; sdram_addr out 13.

Function
REQ-006 Address mapping SHALL be: bank = addr[23:22]; row = addr[21:9]; column = addr[8:0], zero-extended to 13 bits, with A10 driven as the precharge flag.
REQ-007 The FSM states SHALL be S_IDLE, S_REF, S_RFC, S_ACT, S_RCD, S_RD, S_RD_DATA, S_WR, S_WR_DATA, S_PRE and S_RP; work_state SHALL equal the current state.
REQ-008 The FSM SHALL remain in S_IDLE with sdram_cmd = NOP until init_done = 1.
REQ-009 Arbitration in S_IDLE SHALL use the priority refresh-pending > read > write; when a read or write wins, the FSM SHALL latch its address and type and pulse the matching ack for exactly one cycle.
REQ-010 Sequence: ACTIVE for 1 cycle, then S_RCD for T_RCD-1 cycles, then READ or WRITE for 1 cycle, then the DATA state, then PRECHARGE for 1 cycle, then S_RP for T_RP-1 cycles, then S_IDLE.
REQ-011 Read timing: with the READ command issued at cycle t, sdram_data_i_valid SHALL be 1 during cycles t+CL through t+CL+BL-1.
REQ-012 S_RD_DATA SHALL last CL+BL cycles, and end_tread SHALL pulse in its final cycle only.
REQ-013 Write timing: with the WRITE command issued at cycle t, sdram_wr_data_valid and sdram_r_wn=0 SHALL hold for cycles t through t+BL-1.
REQ-014 S_WR_DATA SHALL last BL-1+T_WR cycles, and end_twrite SHALL pulse in its final cycle only.
REQ-015 The refresh counter SHALL count from 0 to REF_PERIOD-1, then wrap to 0 and set ref_pending.
REQ-016 ref_pending SHALL clear on entry to S_REF; refresh SHALL never preempt an active burst.
REQ-017 A refresh SHALL be an AUTO REFRESH command for 1 cycle, then S_RFC for T_RFC-1 cycles, then S_IDLE.
REQ-018 When rd_req and wr_req are asserted together with no refresh pending, read SHALL be served first and write on the next S_IDLE visit.
REQ-019 A request deasserted before its ack SHALL be ignored; no ack SHALL be issued while the FSM is outside S_IDLE.

Reset
REQ-020 While rst = 1, the FSM SHALL be in S_IDLE, all counters and ref_pending SHALL be 0, every ack, valid and end output SHALL be 0, sdram_r_wn SHALL be 1, sdram_cmd SHALL be NOP (0111), and sdram_ba and sdram_addr SHALL be 0.
REQ-021 Reset asserted mid-burst SHALL abort the burst immediately with no further strobes; the device is re-initialised externally.

Configuration
REQ-022 With SDRAM_AUTO_PRECHARGE_EN defined, READ and WRITE SHALL drive A10 = 1, S_PRE SHALL be skipped, and S_RP SHALL be entered directly from the DATA state for T_RP cycles.
REQ-023 Without SDRAM_AUTO_PRECHARGE_EN, A10 SHALL be 0 on READ and WRITE, and an explicit PRECHARGE (A10 = 1) SHALL be issued.

Structure
REQ-024 The state encodings, the SDRAM command encodings (NOP, ACT, RD, WR, PRE, REF) and the default timing constants SHALL reside in the shared sdram_param package/include.
REQ-025 The block SHALL contain one sub-module, sdram_ref_timer, which holds the refresh counter and ref_pending.

Verification
REQ-026 Single read: init_done=1, rd_req with sys_rdaddr=24'hC0_1234 -> ack for 1 cycle; ACT with ba=3, row=0x0009, col=0x034; READ 2 cycles later; data_i_valid high 4 cycles from READ+2; end_tread once.
REQ-027 Single write: wr_req with sys_wraddr=24'h00_0010 -> WRITE cmd; wr_data_valid high 4 cycles with r_wn=0 during them; end_twrite 5 cycles after WRITE; PRECHARGE follows.
REQ-028 Simultaneous rd_req and wr_req -> read ack first, write ack after returning to S_IDLE; no overlap of strobes.
REQ-029 Refresh: hold rd_req continuously -> AUTO REFRESH issued within one burst length of the 780-cycle tick; no ack during S_REF/S_RFC.
REQ-030 Reset mid-read at CL+1 -> all strobes 0 and cmd=NOP in the same cycle; after release, a new read completes normally.
REQ-031 Build with SDRAM_AUTO_PRECHARGE_EN -> READ shows A10=1 and no PRECHARGE command appears.

Source files
------------

// File: rtl/sdram_burst_arb_pkg.sv
// Shared SDRAM definitions for the burst arbiter: FSM state encodings,
// command encodings {cs_n,ras_n,cas_n,we_n}, default timing constants, column-address helper.
package sdram_param;

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_REF     = 5'd1,
        S_RFC     = 5'd2,
        S_ACT     = 5'd3,
        S_RCD     = 5'd4,
        S_RD      = 5'd5,
        S_RD_DATA = 5'd6,
        S_WR      = 5'd7,
        S_WR_DATA = 5'd8,
        S_PRE     = 5'd9,
        S_RP      = 5'd10
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam int DEF_BL         = 4;
    localparam int DEF_CL         = 2;
    localparam int DEF_T_RCD      = 2;
    localparam int DEF_T_RP       = 2;
    localparam int DEF_T_WR       = 2;
    localparam int DEF_T_RFC      = 7;
    localparam int DEF_REF_PERIOD = 780;

    // Column on A8..A0, A10 carries the auto-precharge flag, A9/A11/A12 zero.
    function automatic logic [12:0] col_addr(input logic [23:0] a, input logic ap);
        return {2'b00, ap, 1'b0, a[8:0]};
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval counter; raises ref_pending on every wrap
// and drops it when the arbiter enters S_REF.
module sdram_ref_timer
    import sdram_param::*;
#(
    parameter int REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_clr,
    output logic ref_pending
);

    localparam int CW = $clog2(REF_PERIOD + 1);

    logic [CW-1:0] ref_cnt;
    logic          wrap;

    assign wrap = (ref_cnt == CW'(REF_PERIOD - 1));

    // NOTE: sequential state uses non-blocking assignments only; the later
    // ref_pending assignment wins, so a new tick beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
            if (ref_clr)
                ref_pending <= 1'b0;
            if (wrap)
                ref_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_burst_arb.sv
// Single-port SDRAM burst arbiter: refresh > read > write, one burst per grant.
// Define SDRAM_AUTO_PRECHARGE_EN to use READ/WRITE with auto-precharge instead of explicit PRECHARGE.
module sdram_burst_arb
    import sdram_param::*;
#(
    parameter int BL         = DEF_BL,
    parameter int CL         = DEF_CL,
    parameter int T_RCD      = DEF_T_RCD,
    parameter int T_RP       = DEF_T_RP,
    parameter int T_WR       = DEF_T_WR,
    parameter int T_RFC      = DEF_T_RFC,
    parameter int REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        sdram_rd_req,
    output logic        sdram_rd_ack,
    input  logic [23:0] sys_rdaddr,
    input  logic        sdram_wr_req,
    output logic        sdram_wr_ack,
    input  logic [23:0] sys_wraddr,
    output logic        sdram_wr_data_valid,
    output logic        sdram_data_i_valid,
    output logic        end_tread,
    output logic        end_twrite,
    output logic        sdram_r_wn,
    output logic [4:0]  work_state,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr
);

`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam logic AP = 1'b1;
`else
    localparam logic AP = 1'b0;
`endif

    localparam int RCD_CYC = T_RCD - 1;
    localparam int RD_CYC  = CL + BL;
    localparam int WR_CYC  = BL - 1 + T_WR;
    localparam int RFC_CYC = T_RFC - 1;
    localparam int RP_CYC  = AP ? T_RP : T_RP - 1;

    state_t      state, state_next, after_data, cmd_state;
    logic [15:0] cnt;
    logic [23:0] addr_q;
    logic        is_rd_q;
    logic        ref_pending;
    logic        arb_ok, ref_win, rd_win, wr_win;

    assign arb_ok  = (state == S_IDLE) && init_done && !rst;
    assign ref_win = arb_ok && ref_pending;
    assign rd_win  = arb_ok && !ref_pending && sdram_rd_req;
    assign wr_win  = arb_ok && !ref_pending && !sdram_rd_req && sdram_wr_req;

    assign after_data = AP ? S_RP : S_PRE;
    assign cmd_state  = is_rd_q ? S_RD : S_WR;

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .ref_clr     (ref_win),
        .ref_pending (ref_pending)
    );

    // cnt is the cycle index inside the current state, restarted on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            is_rd_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state || state == S_IDLE) ? '0 : cnt + 1'b1;
            if (rd_win || wr_win) begin
                addr_q  <= rd_win ? sys_rdaddr : sys_wraddr;
                is_rd_q <= rd_win;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (ref_win) state_next = S_REF;
                       else if (rd_win || wr_win) state_next = S_ACT;
            S_REF:     state_next = (RFC_CYC > 0) ? S_RFC : S_IDLE;
            S_RFC:     if (cnt == 16'(RFC_CYC - 1)) state_next = S_IDLE;
            S_ACT:     state_next = (RCD_CYC > 0) ? S_RCD : cmd_state;
            S_RCD:     if (cnt == 16'(RCD_CYC - 1)) state_next = cmd_state;
            S_RD:      state_next = S_RD_DATA;
            S_RD_DATA: if (cnt == 16'(RD_CYC - 1)) state_next = after_data;
            S_WR:      state_next = (WR_CYC > 0) ? S_WR_DATA : after_data;
            S_WR_DATA: if (cnt == 16'(WR_CYC - 1)) state_next = after_data;
            S_PRE:     state_next = (RP_CYC > 0) ? S_RP : S_IDLE;
            S_RP:      if (cnt == 16'(RP_CYC - 1)) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sdram_cmd           = CMD_NOP;
        sdram_ba            = 2'b00;
        sdram_addr          = 13'h0000;
        sdram_data_i_valid  = 1'b0;
        sdram_wr_data_valid = 1'b0;
        end_tread           = 1'b0;
        end_twrite          = 1'b0;
        case (state)
            S_REF: sdram_cmd = CMD_REF;
            S_ACT: begin
                sdram_cmd  = CMD_ACT;
                sdram_ba   = addr_q[23:22];
                sdram_addr = addr_q[21:9];
            end
            S_RD: begin
                sdram_cmd  = CMD_RD;
                sdram_ba   = addr_q[23:22];
                sdram_addr = col_addr(addr_q, AP);
            end
            S_RD_DATA: begin
                // Read data returns CL cycles after READ; cnt 0 is the cycle after READ.
                sdram_data_i_valid = (cnt >= 16'(CL - 1)) && (cnt <= 16'(CL + BL - 2));
                end_tread          = (cnt == 16'(RD_CYC - 1));
            end
            S_WR: begin
                sdram_cmd           = CMD_WR;
                sdram_ba            = addr_q[23:22];
                sdram_addr          = col_addr(addr_q, AP);
                sdram_wr_data_valid = 1'b1;
            end
            S_WR_DATA: begin
                sdram_wr_data_valid = (cnt <= 16'(BL - 2));
                end_twrite          = (cnt == 16'(WR_CYC - 1));
            end
            S_PRE: begin
                sdram_cmd  = CMD_PRE;
                sdram_ba   = addr_q[23:22];
                sdram_addr = 13'h0400;
            end
            default: ;
        endcase
    end

    assign sdram_r_wn   = !sdram_wr_data_valid;
    assign sdram_rd_ack = rd_win;
    assign sdram_wr_ack = wr_win;
    assign work_state   = state;

endmodule

// File: tb/tb_sdram_burst_arb.sv
// Directed bench for sdram_burst_arb; expectations follow SDRAM_AUTO_PRECHARGE_EN when defined.
module tb_sdram_burst_arb;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RDC = 4'b0101;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam int          EXP_RD_PRE = -1;
    localparam int          EXP_WR_PRE = -1;
    localparam logic [12:0] EXP_RD_COL = 13'h0434;
    localparam logic [12:0] EXP_WR_COL = 13'h0410;
`else
    localparam int          EXP_RD_PRE = 10;
    localparam int          EXP_WR_PRE = 9;
    localparam logic [12:0] EXP_RD_COL = 13'h0034;
    localparam logic [12:0] EXP_WR_COL = 13'h0010;
`endif

    logic        clk = 1'b0;
    logic        rst, init_done;
    logic        sdram_rd_req, sdram_rd_ack, sdram_wr_req, sdram_wr_ack;
    logic [23:0] sys_rdaddr, sys_wraddr;
    logic        sdram_wr_data_valid, sdram_data_i_valid, end_tread, end_twrite, sdram_r_wn;
    logic [4:0]  work_state;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    sdram_burst_arb dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_done           (init_done),
        .sdram_rd_req        (sdram_rd_req),
        .sdram_rd_ack        (sdram_rd_ack),
        .sys_rdaddr          (sys_rdaddr),
        .sdram_wr_req        (sdram_wr_req),
        .sdram_wr_ack        (sdram_wr_ack),
        .sys_wraddr          (sys_wraddr),
        .sdram_wr_data_valid (sdram_wr_data_valid),
        .sdram_data_i_valid  (sdram_data_i_valid),
        .end_tread           (end_tread),
        .end_twrite          (end_twrite),
        .sdram_r_wn          (sdram_r_wn),
        .work_state          (work_state),
        .sdram_cmd           (sdram_cmd),
        .sdram_ba            (sdram_ba),
        .sdram_addr          (sdram_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observations of one trace window, indexed in cycles from its first sample.
    int act_at, rdwr_at, pre_at, ref_at, idle_at;
    int vfirst, vcnt, wvfirst, wvcnt, rwn_low, rwn_bad, overlap, non_nop;
    int end_rd_at, end_rd_cnt, end_wr_at, end_wr_cnt;
    int rdack_at, rdack_cnt, wrack_at, wrack_cnt, ack_in_ref, ack_after_ref;
    logic [1:0]  act_ba;
    logic [12:0] act_row, rdwr_addr, pre_addr;
    bit hold_rd = 1'b0;

    task automatic trace(input int n);
        logic prev_rd, prev_wr, left_idle;
        act_at = -1; rdwr_at = -1; pre_at = -1; ref_at = -1; idle_at = -1;
        vfirst = -1; vcnt = 0; wvfirst = -1; wvcnt = 0; rwn_low = 0; rwn_bad = 0;
        overlap = 0; non_nop = 0; end_rd_at = -1; end_rd_cnt = 0; end_wr_at = -1;
        end_wr_cnt = 0; rdack_at = -1; rdack_cnt = 0; wrack_at = -1; wrack_cnt = 0;
        ack_in_ref = 0; ack_after_ref = -1;
        act_ba = '0; act_row = '0; rdwr_addr = '0; pre_addr = '0;
        prev_rd = 1'b0; prev_wr = 1'b0; left_idle = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (prev_rd && !hold_rd) sdram_rd_req = 1'b0;
                if (prev_wr) sdram_wr_req = 1'b0;
            end
            #1;
            prev_rd = sdram_rd_ack;
            prev_wr = sdram_wr_ack;
            if (sdram_cmd != NOP) non_nop++;
            if (sdram_cmd == ACT && act_at < 0) begin
                act_at = i; act_ba = sdram_ba; act_row = sdram_addr;
            end
            if ((sdram_cmd == RDC || sdram_cmd == WRC) && rdwr_at < 0) begin
                rdwr_at = i; rdwr_addr = sdram_addr;
            end
            if (sdram_cmd == PRE && pre_at < 0) begin
                pre_at = i; pre_addr = sdram_addr;
            end
            if (sdram_cmd == REF && ref_at < 0) ref_at = i;
            if (sdram_data_i_valid) begin
                vcnt++; if (vfirst < 0) vfirst = i;
            end
            if (sdram_wr_data_valid) begin
                wvcnt++; if (wvfirst < 0) wvfirst = i;
            end
            if (!sdram_r_wn) rwn_low++;
            if (sdram_r_wn == sdram_wr_data_valid) rwn_bad++;
            if (sdram_data_i_valid && sdram_wr_data_valid) overlap++;
            if (end_tread) begin
                end_rd_cnt++; if (end_rd_at < 0) end_rd_at = i;
            end
            if (end_twrite) begin
                end_wr_cnt++; if (end_wr_at < 0) end_wr_at = i;
            end
            if (sdram_rd_ack) begin
                rdack_cnt++; if (rdack_at < 0) rdack_at = i;
                if (ref_at >= 0 && ack_after_ref < 0) ack_after_ref = i;
            end
            if (sdram_wr_ack) begin
                wrack_cnt++; if (wrack_at < 0) wrack_at = i;
            end
            if ((work_state == 5'd1 || work_state == 5'd2) && (sdram_rd_ack || sdram_wr_ack))
                ack_in_ref++;
            if (work_state != 5'd0) left_idle = 1'b1;
            else if (left_idle && idle_at < 0) idle_at = i;
        end
    endtask

    initial begin
        rst = 1'b1; init_done = 1'b1; sdram_rd_req = 1'b1; sdram_wr_req = 1'b1;
        sys_rdaddr = 24'hC0_1234; sys_wraddr = 24'h00_0010;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", work_state, 0);
        check("rst_cmd", sdram_cmd, NOP);
        check("rst_r_wn", sdram_r_wn, 1);
        check("rst_ba_addr", {sdram_ba, sdram_addr}, 0);
        check("rst_acks", {sdram_rd_ack, sdram_wr_ack}, 0);
        check("rst_strobes", {sdram_data_i_valid, sdram_wr_data_valid, end_tread, end_twrite}, 0);

        // init_done low: requests are held off
        @(negedge clk);
        rst = 1'b0; init_done = 1'b0; sdram_wr_req = 1'b0;
        trace(5);
        check("noinit_ack", rdack_cnt, 0);
        check("noinit_cmd", non_nop, 0);

        // single read
        @(negedge clk);
        init_done = 1'b1; sdram_rd_req = 1'b1;
        trace(14);
        check("rd_ack_cnt", rdack_cnt, 1);
        check("rd_ack_at", rdack_at, 0);
        check("rd_act_at", act_at, 1);
        check("rd_act_ba", act_ba, 3);
        check("rd_act_row", act_row, 13'h0009);
        check("rd_cmd_at", rdwr_at, 3);
        check("rd_col", rdwr_addr, EXP_RD_COL);
        check("rd_valid_first", vfirst, 5);
        check("rd_valid_cnt", vcnt, 4);
        check("rd_end_at", end_rd_at, 9);
        check("rd_end_cnt", end_rd_cnt, 1);
        check("rd_pre_at", pre_at, EXP_RD_PRE);
        check("rd_idle_at", idle_at, 12);
        check("rd_no_wstrobe", wvcnt, 0);

        // single write
        @(negedge clk);
        sdram_wr_req = 1'b1;
        trace(13);
        check("wr_ack_cnt", wrack_cnt, 1);
        check("wr_act_bank_row", {act_ba, act_row}, 0);
        check("wr_cmd_at", rdwr_at, 3);
        check("wr_col", rdwr_addr, EXP_WR_COL);
        check("wr_valid_first", wvfirst, 3);
        check("wr_valid_cnt", wvcnt, 4);
        check("wr_rwn_low", rwn_low, 4);
        check("wr_rwn_track", rwn_bad, 0);
        check("wr_end_at", end_wr_at, 8);
        check("wr_end_cnt", end_wr_cnt, 1);
        check("wr_pre_at", pre_at, EXP_WR_PRE);
`ifndef SDRAM_AUTO_PRECHARGE_EN
        check("wr_pre_a10", pre_addr, 13'h0400);
`endif
        check("wr_idle_at", idle_at, 11);

        // simultaneous read and write requests
        @(negedge clk);
        sdram_rd_req = 1'b1; sdram_wr_req = 1'b1;
        trace(26);
        check("sim_rd_ack_at", rdack_at, 0);
        check("sim_wr_ack_at", wrack_at, 12);
        check("sim_ack_cnts", {rdack_cnt[15:0], wrack_cnt[15:0]}, 32'h0001_0001);
        check("sim_rd_valid_first", vfirst, 5);
        check("sim_wr_valid_first", wvfirst, 15);
        check("sim_overlap", overlap, 0);
        check("sim_wr_end_at", end_wr_at, 20);

        // reset in the middle of read data
        @(negedge clk);
        sdram_rd_req = 1'b1;
        trace(7);
        check("mid_valid_before_rst", vcnt, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {sdram_data_i_valid, end_tread}, 0);
        check("mid_rst_cmd", sdram_cmd, NOP);
        check("mid_rst_state", work_state, 0);
        check("mid_rst_r_wn", sdram_r_wn, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sdram_rd_req = 1'b1;
        trace(14);
        check("post_rst_valid_cnt", vcnt, 4);
        check("post_rst_end_cnt", end_rd_cnt, 1);
        check("post_rst_idle_at", idle_at, 12);

        // refresh tick with a continuously requesting reader
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; hold_rd = 1'b1; sdram_rd_req = 1'b1;
        trace(800);
        check("ref_at", ref_at, 781);
        check("ref_no_ack", ack_in_ref, 0);
        check("ref_ack_after", ack_after_ref, 788);
        check("ref_rd_ack_cnt", rdack_cnt, 66);
        hold_rd = 1'b0; sdram_rd_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
